force_accumulator: RTL and testbench
====================================

// Module: force_accumulator
// PURPOSE
//  Downstream of the per-node force generators (torque, spring, gravity stages).
//  Sums the streamed per-node force beats from NUM_SOURCES sequential sources into one
//  saturating (x,y) total per node. It pulses done when every source has reported,
//  handing totals to the integrator.
//  Beats arrive in node order 0..NUM_NODES-1 per source; each source ends with a result pulse.
// PARAMETERS
//  NUM_NODES    10  nodes per body; beats expected per source
//  FORCE_SIZE   8   width of signed incoming force components
//  ACC_SIZE     12  width of signed per-node accumulators (>= FORCE_SIZE)
//  NUM_SOURCES  3   source result pulses required before done_out
// PORTS
//  clk_in          in   1                          system clock
//  rst_in          in   1                          synchronous active-high reset
//  begin_in        in   1                          start accumulation frame (1-cycle pulse)
//  force_x_in      in   FORCE_SIZE signed          x force of current beat
//  force_y_in      in   FORCE_SIZE signed          y force of current beat
//  force_valid_in  in   1                          beat valid; one node per valid cycle
//  result_in       in   1                          current source finished (1-cycle pulse)
//  forces_out      out  [1:0][NUM_NODES] ACC_SIZE  totals, [0]=x [1]=y, indexed by node
//  busy_out        out  1                          high in ACCUM
//  done_out        out  1                          1-cycle pulse, forces_out final
//  error_out       out  1                          sticky per frame: beat-count mismatch
// BEHAVIOUR
//  Reset: state=IDLE; all forces_out=0; busy_out=0; done_out=0; error_out=0.
//   Reset also covers mid-frame: the partial frame is discarded.
//   Node index and source count are cleared.
//  States: IDLE -> ACCUM on begin_in; ACCUM -> IDLE on the NUM_SOURCES-th result_in.
//  begin_in in IDLE, same edge:
//   - clear all accumulators, node_idx=0, src_cnt=0, error_out=0
//   - busy_out<=1
//  begin_in in ACCUM: ignored.
//  ACCUM, force_valid_in=1 with node_idx<NUM_NODES:
//   - acc[*][node_idx] <= sat(acc + sign-extended force); node_idx++
//   - totals visible on forces_out the next cycle
//  ACCUM, force_valid_in=1 with node_idx==NUM_NODES:
//   - beat dropped; error_out<=1
//  result_in in ACCUM:
//   - if node_idx != NUM_NODES (counting a same-cycle beat): error_out<=1
//   - node_idx<=0; src_cnt++
//  force_valid_in and result_in in the same cycle:
//   - beat accumulated first at old node_idx, then node_idx<=0
//  Final source (src_cnt==NUM_SOURCES-1 and result_in):
//   - state<=IDLE, busy_out<=0, done_out<=1 for exactly one cycle
//   - latency: done_out is high the cycle after the last result_in
//  force_valid_in / result_in while IDLE: ignored; accumulators hold their values.
//  Saturation: compute in ACC_SIZE+1 bits, clamp to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
//   - sticky per node; later opposite-sign beats start from the clamped value
//  x and y are independent; forces_out is held stable from done_out until the next begin_in.
// TESTING
//  1 Reset, then begin; 3 sources each send x=+1,y=-2 for nodes 0..9, each followed by result.
//    -> done_out is 1 cycle after the 3rd result; every node = (3,-6); error_out=0.
//  2 ACC_SIZE=12; one node gets 20 beats of +127 across sources.
//    -> x clamps at 2047, then one -128 beat -> 1919.
//  3 Same setup with -128 beats. -> clamps at -2048, no wrap to positive.
//  4 Source sends 9 beats then result. -> error_out=1; node 9 unchanged.
//    An 11th beat in another frame -> dropped, error_out=1.
//  5 Last beat and result in the same cycle. -> node 9 updated, node_idx=0, no error.
//    begin_in during ACCUM is ignored.
//  6 rst_in asserted mid-frame after 5 beats. -> next cycle: all outputs 0, IDLE.
//    A new begin then completes normally.

Source files
------------

// File: rtl/force_accumulator_if.sv
// rtl/force_accumulator_if.sv - beat/result stream and totals bundle for force_accumulator
interface force_accumulator_if #(
    parameter int NUM_NODES  = 10,
    parameter int FORCE_SIZE = 8,
    parameter int ACC_SIZE   = 12
);
    logic                                          begin_in;
    logic signed [FORCE_SIZE-1:0]                  force_x_in;
    logic signed [FORCE_SIZE-1:0]                  force_y_in;
    logic                                          force_valid_in;
    logic                                          result_in;
    logic [1:0][NUM_NODES-1:0][ACC_SIZE-1:0]       forces_out;
    logic                                          busy_out;
    logic                                          done_out;
    logic                                          error_out;

    modport master (
        output begin_in, force_x_in, force_y_in, force_valid_in, result_in,
        input  forces_out, busy_out, done_out, error_out
    );

    modport slave (
        input  begin_in, force_x_in, force_y_in, force_valid_in, result_in,
        output forces_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/force_accumulator.sv
// rtl/force_accumulator.sv - saturating per-node (x,y) force sum over NUM_SOURCES streamed sources
module force_accumulator #(
    parameter int NUM_NODES   = 10,
    parameter int FORCE_SIZE  = 8,
    parameter int ACC_SIZE    = 12,
    parameter int NUM_SOURCES = 3
) (
    input logic               clk_in,
    input logic               rst_in,
    force_accumulator_if.slave bus
);
    localparam int NW = $clog2(NUM_NODES + 1);
    localparam int SW = $clog2(NUM_SOURCES + 1);
    localparam logic [NW-1:0] NODE_END = NW'(NUM_NODES);
    localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SOURCES - 1);
    localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                      state, state_next;
    logic signed [ACC_SIZE-1:0]  acc_x [NUM_NODES];
    logic signed [ACC_SIZE-1:0]  acc_y [NUM_NODES];
    logic [NW-1:0]               node_idx;
    logic [NW-1:0]               node_next;
    logic [SW-1:0]               src_cnt;
    logic                        done_r;
    logic                        error_r;
    logic                        beat_take;
    logic                        beat_drop;
    logic                        frame_end;

    // One guard bit catches overflow; clamping keeps the node pinned until an opposite beat.
    function automatic logic signed [ACC_SIZE-1:0] sat_add(
        input logic signed [ACC_SIZE-1:0]   acc,
        input logic signed [FORCE_SIZE-1:0] f
    );
        logic signed [ACC_SIZE:0] s;
        s = $signed({acc[ACC_SIZE-1], acc}) + $signed({{(ACC_SIZE+1-FORCE_SIZE){f[FORCE_SIZE-1]}}, f});
        if (s[ACC_SIZE] != s[ACC_SIZE-1])
            return s[ACC_SIZE] ? ACC_MIN : ACC_MAX;
        return s[ACC_SIZE-1:0];
    endfunction

    always_comb begin
        beat_take = 1'b0;
        beat_drop = 1'b0;
        frame_end = 1'b0;
        state_next = state;
        if (state == ACCUM) begin
            beat_take = bus.force_valid_in && (node_idx < NODE_END);
            beat_drop = bus.force_valid_in && (node_idx >= NODE_END);
            frame_end = bus.result_in && (src_cnt == LAST_SRC);
        end
        node_next = beat_take ? node_idx + NW'(1) : node_idx;
        case (state)
            IDLE:    if (bus.begin_in) state_next = ACCUM;
            ACCUM:   if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                acc_x[n] <= '0;
                acc_y[n] <= '0;
            end
            node_idx <= '0;
            src_cnt  <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.begin_in) begin
                    for (int n = 0; n < NUM_NODES; n++) begin
                        acc_x[n] <= '0;
                        acc_y[n] <= '0;
                    end
                    node_idx <= '0;
                    src_cnt  <= '0;
                    error_r  <= 1'b0;
                end
            end else begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    if (beat_take && node_idx == NW'(n)) begin
                        acc_x[n] <= sat_add(acc_x[n], bus.force_x_in);
                        acc_y[n] <= sat_add(acc_y[n], bus.force_y_in);
                    end
                end
                if (beat_drop) error_r <= 1'b1;
                if (bus.result_in) begin
                    if (node_next != NODE_END) error_r <= 1'b1;
                    node_idx <= '0;
                    src_cnt  <= src_cnt + SW'(1);
                    if (frame_end) done_r <= 1'b1;
                end else begin
                    node_idx <= node_next;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_NODES; n++) begin
            bus.forces_out[0][n] = acc_x[n];
            bus.forces_out[1][n] = acc_y[n];
        end
        bus.busy_out  = (state == ACCUM);
        bus.done_out  = done_r;
        bus.error_out = error_r;
    end
endmodule

// File: tb/tb_force_accumulator.sv
// tb/tb_force_accumulator.sv - directed self-checking bench for force_accumulator
module tb_force_accumulator;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    force_accumulator_if #(.NUM_NODES(10), .FORCE_SIZE(8), .ACC_SIZE(12)) a ();
    force_accumulator_if #(.NUM_NODES(1),  .FORCE_SIZE(8), .ACC_SIZE(12)) b ();

    force_accumulator #(.NUM_NODES(10), .FORCE_SIZE(8), .ACC_SIZE(12), .NUM_SOURCES(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .bus(a)
    );
    force_accumulator #(.NUM_NODES(1), .FORCE_SIZE(8), .ACC_SIZE(12), .NUM_SOURCES(21)) dut_sat (
        .clk_in(clk_in), .rst_in(rst_in), .bus(b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int fx(input int n);
        return int'($signed(a.forces_out[0][n]));
    endfunction

    function automatic int fy(input int n);
        return int'($signed(a.forces_out[1][n]));
    endfunction

    function automatic int nodes_not(input int ex, input int ey);
        int bad = 0;
        for (int n = 0; n < 10; n++)
            if (fx(n) != ex || fy(n) != ey) bad++;
        return bad;
    endfunction

    task automatic a_beat(input int x, input int y, input bit res);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        a.force_valid_in = 1'b1;
        a.force_x_in     = xv[7:0];
        a.force_y_in     = yv[7:0];
        a.result_in      = res;
        tick();
        a.force_valid_in = 1'b0;
        a.result_in      = 1'b0;
    endtask

    task automatic a_result();
        a.result_in = 1'b1;
        tick();
        a.result_in = 1'b0;
    endtask

    task automatic a_begin();
        a.begin_in = 1'b1;
        tick();
        a.begin_in = 1'b0;
    endtask

    task automatic a_source(input int beats, input int x, input int y);
        for (int i = 0; i < beats; i++) a_beat(x, y, 1'b0);
        a_result();
    endtask

    task automatic b_beat(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        b.force_valid_in = 1'b1;
        b.force_x_in     = xv[7:0];
        b.force_y_in     = yv[7:0];
        tick();
        b.force_valid_in = 1'b0;
    endtask

    task automatic b_result();
        b.result_in = 1'b1;
        tick();
        b.result_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        a.begin_in = 0; a.force_x_in = 0; a.force_y_in = 0; a.force_valid_in = 0; a.result_in = 0;
        b.begin_in = 0; b.force_x_in = 0; b.force_y_in = 0; b.force_valid_in = 0; b.result_in = 0;

        // reset state and basic three-source frame
        do_reset();
        check("rst_busy", int'(a.busy_out), 0);
        check("rst_done", int'(a.done_out), 0);
        check("rst_err", int'(a.error_out), 0);
        check("rst_forces", nodes_not(0, 0), 0);
        a_begin();
        check("t1_busy", int'(a.busy_out), 1);
        a_source(10, 1, -2);
        a_source(10, 1, -2);
        check("t1_not_done", int'(a.done_out), 0);
        a_source(10, 1, -2);
        check("t1_done", int'(a.done_out), 1);
        check("t1_busy_low", int'(a.busy_out), 0);
        check("t1_nodes", nodes_not(3, -6), 0);
        check("t1_n9_y", fy(9), -6);
        check("t1_err", int'(a.error_out), 0);
        tick();
        check("t1_done_pulse", int'(a.done_out), 0);
        check("t1_hold", fx(0), 3);

        // short source: 9 beats then result
        a_begin();
        a_source(9, 5, 5);
        check("t4_short_err", int'(a.error_out), 1);
        check("t4_n9_unchanged", fx(9), 0);
        check("t4_n8", fx(8), 5);
        do_reset();

        // 11th beat dropped
        a_begin();
        for (int i = 0; i < 11; i++) a_beat(1, 1, 1'b0);
        check("t4_long_err", int'(a.error_out), 1);
        check("t4_long_n9", fx(9), 1);
        check("t4_long_n0", fx(0), 1);
        a_result();
        a_source(10, 1, 1);
        a_source(10, 1, 1);
        check("t4_long_done", int'(a.done_out), 1);
        check("t4_err_sticky", int'(a.error_out), 1);
        check("t4_long_n0_final", fx(0), 3);

        // last beat with result in same cycle; begin during ACCUM ignored
        a_begin();
        check("t5_err_cleared", int'(a.error_out), 0);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 9; i++) begin
                if (s == 1 && i == 5) a.begin_in = 1'b1;
                a_beat(7, -7, 1'b0);
                a.begin_in = 1'b0;
            end
            a_beat(7, -7, 1'b1);
            if (s == 0) check("t5_n9_first", fx(9), 7);
        end
        check("t5_done", int'(a.done_out), 1);
        check("t5_err", int'(a.error_out), 0);
        check("t5_n0", fx(0), 21);
        check("t5_n9_y", fy(9), -21);
        tick();
        // IDLE ignores beats and results
        a_beat(50, 50, 1'b1);
        a_result();
        check("idle_hold_x", fx(0), 21);
        check("idle_busy", int'(a.busy_out), 0);
        check("idle_done", int'(a.done_out), 0);

        // reset mid-frame, then a clean frame
        a_begin();
        for (int i = 0; i < 5; i++) a_beat(2, 2, 1'b0);
        check("t6_partial", fx(4), 2);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("t6_busy", int'(a.busy_out), 0);
        check("t6_done", int'(a.done_out), 0);
        check("t6_err", int'(a.error_out), 0);
        check("t6_forces", nodes_not(0, 0), 0);
        a_begin();
        a_source(10, 1, 1);
        a_source(10, 1, 1);
        a_source(10, 1, 1);
        check("t6_done_new", int'(a.done_out), 1);
        check("t6_nodes_new", nodes_not(3, 3), 0);
        check("t6_err_new", int'(a.error_out), 0);

        // saturation on single-node instance with 21 sources
        b.begin_in = 1'b1;
        tick();
        b.begin_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_beat(127, 0);
            if (i == 15) check("t2_x_16", int'($signed(b.forces_out[0][0])), 2032);
            b_result();
        end
        check("t2_x_clamp", int'($signed(b.forces_out[0][0])), 2047);
        b_beat(-128, 0);
        check("t2_x_recover", int'($signed(b.forces_out[0][0])), 1919);
        check("t2_y_indep", int'($signed(b.forces_out[1][0])), 0);
        b_result();
        check("t2_done", int'(b.done_out), 1);
        check("t2_err", int'(b.error_out), 0);

        b.begin_in = 1'b1;
        tick();
        b.begin_in = 1'b0;
        for (int i = 0; i < 21; i++) begin
            b_beat(-128, 127);
            b_result();
        end
        check("t3_done", int'(b.done_out), 1);
        check("t3_x_clamp_neg", int'($signed(b.forces_out[0][0])), -2048);
        check("t3_y_clamp_pos", int'($signed(b.forces_out[1][0])), 2047);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
